// File: rtl/fir_mon_pkg.sv
// ----------------------------------------------------------------------------
// fir_mon_pkg : shared types, default widths and saturating add for the
//               FIR error monitor.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fir_mon_pkg;

   localparam int DW    = 16;
   localparam int CNT_W = 16;
   localparam int ACC_W = 40;
   localparam int SQ_W  = 56;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Adds two unsigned values and clamps at the all-ones value of 'width' bits (width <= 64).
   function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                           input logic [63:0] inc,
                                           input int unsigned width);
      logic [64:0] sum;
      logic [63:0] lim;
      lim = {64{1'b1}} >> (64 - width);
      sum = {1'b0, acc} + {1'b0, inc};
      if (sum > {1'b0, lim}) begin
         sat_add = lim;
      end else begin
         sat_add = sum[63:0];
      end
   endfunction

endpackage

`default_nettype wire

// File: rtl/fir_error_monitor_abs_diff.sv
// ----------------------------------------------------------------------------
// fir_abs_diff : combinational signed difference and magnitude of two samples.
//                Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fir_abs_diff
   import fir_mon_pkg::*;
#(
   parameter int DW = fir_mon_pkg::DW
) (
   input  logic signed [DW-1:0] y_apx_i,
   input  logic signed [DW-1:0] y_ref_i,
   output logic signed [DW:0]   d_o,
   output logic        [DW-1:0] a_o
);

   // One extra bit makes the difference exact for every input pair.
   assign d_o = {y_apx_i[DW-1], y_apx_i} - {y_ref_i[DW-1], y_ref_i};
   assign a_o = d_o[DW] ? DW'(-d_o) : d_o[DW-1:0];

endmodule

`default_nettype wire

// File: rtl/fir_error_monitor.sv
// ----------------------------------------------------------------------------
// fir_error_monitor : windowed error statistics between approximate and exact
//                     FIR outputs. Optional squared error via ERR_SQ_EN.
//                     Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fir_error_monitor
   import fir_mon_pkg::*;
#(
   parameter int DW    = fir_mon_pkg::DW,
   parameter int CNT_W = fir_mon_pkg::CNT_W,
   parameter int ACC_W = fir_mon_pkg::ACC_W,
   parameter int SQ_W  = fir_mon_pkg::SQ_W
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 start,
   input  logic [CNT_W-1:0]     num_samples,
   input  logic                 valid_in,
   input  logic signed [DW-1:0] y_apx,
   input  logic signed [DW-1:0] y_ref,
   output logic                 busy,
   output logic                 done,
   output logic [ACC_W-1:0]     err_sum,
   output logic [DW-1:0]        err_max,
   output logic [CNT_W-1:0]     err_cnt,
   output logic [CNT_W-1:0]     sample_cnt
`ifdef ERR_SQ_EN
   ,
   output logic [SQ_W-1:0]      err_sq_sum
`endif
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic [CNT_W-1:0]  rx_q, rx_d;
   logic [CNT_W-1:0]  rx_inc;
   logic              accept;

   logic              s1_vld_q;
   logic [DW-1:0]     s1_a_q;
   logic              s1_nz_q;

   logic [ACC_W-1:0]  sum_q, sum_d;
   logic [DW-1:0]     max_q, max_d;
   logic [CNT_W-1:0]  ecnt_q, ecnt_d;
   logic [CNT_W-1:0]  scnt_q, scnt_d;

   logic signed [DW:0] diff;
   logic [DW-1:0]      mag;

   fir_abs_diff #(.DW(DW)) u_abs_diff (
      .y_apx_i (y_apx),
      .y_ref_i (y_ref),
      .d_o     (diff),
      .a_o     (mag)
   );

`ifdef ERR_SQ_EN
   logic [2*DW-1:0]  sq;
   logic [2*DW-1:0]  s1_sq_q;
   logic [SQ_W-1:0]  sqsum_q, sqsum_d;

   // The full signed product is 2*DW+2 bits; a square of |d| <= 2^DW-1 always fits in 2*DW.
   assign sq = (2*DW)'($signed({{(DW+1){diff[DW]}}, diff}) * $signed({{(DW+1){diff[DW]}}, diff}));
`endif

   assign rx_inc = rx_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      num_d   = num_q;
      rx_d    = rx_q;
      accept  = 1'b0;
      sum_d   = sum_q;
      max_d   = max_q;
      ecnt_d  = ecnt_q;
      scnt_d  = scnt_q;
`ifdef ERR_SQ_EN
      sqsum_d = sqsum_q;
`endif

      if (s1_vld_q) begin
         sum_d  = ACC_W'(sat_add(64'(sum_q), 64'(s1_a_q), ACC_W));
         max_d  = (s1_a_q > max_q) ? s1_a_q : max_q;
         ecnt_d = ecnt_q + CNT_W'(s1_nz_q);
         scnt_d = scnt_q + CNT_W'(1);
`ifdef ERR_SQ_EN
         sqsum_d = SQ_W'(sat_add(64'(sqsum_q), 64'(s1_sq_q), SQ_W));
`endif
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               num_d  = num_samples;
               rx_d   = '0;
               sum_d  = '0;
               max_d  = '0;
               ecnt_d = '0;
               scnt_d = '0;
`ifdef ERR_SQ_EN
               sqsum_d = '0;
`endif
               state_d = (num_samples == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (valid_in) begin
               accept = 1'b1;
               rx_d   = rx_inc;
               if (rx_inc == num_q) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         num_q    <= '0;
         rx_q     <= '0;
         s1_vld_q <= 1'b0;
         s1_a_q   <= '0;
         s1_nz_q  <= 1'b0;
         sum_q    <= '0;
         max_q    <= '0;
         ecnt_q   <= '0;
         scnt_q   <= '0;
`ifdef ERR_SQ_EN
         s1_sq_q  <= '0;
         sqsum_q  <= '0;
`endif
      end else begin
         num_q    <= num_d;
         rx_q     <= rx_d;
         s1_vld_q <= accept;
         if (accept) begin
            s1_a_q  <= mag;
            s1_nz_q <= (diff != '0);
`ifdef ERR_SQ_EN
            s1_sq_q <= sq;
`endif
         end
         sum_q    <= sum_d;
         max_q    <= max_d;
         ecnt_q   <= ecnt_d;
         scnt_q   <= scnt_d;
`ifdef ERR_SQ_EN
         sqsum_q  <= sqsum_d;
`endif
      end
   end

   assign busy       = (state_q == RUN) || (state_q == DRAIN);
   assign done       = (state_q == DONE);
   assign err_sum    = sum_q;
   assign err_max    = max_q;
   assign err_cnt    = ecnt_q;
   assign sample_cnt = scnt_q;
`ifdef ERR_SQ_EN
   assign err_sq_sum = sqsum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_error_monitor.sv
// ----------------------------------------------------------------------------
// tb_fir_error_monitor : randomized scoreboard bench for fir_error_monitor,
//                        two instances (wide and 17-bit saturating accumulator).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fir_error_monitor;

   localparam int DW    = 16;
   localparam int CNT_W = 16;
   localparam int SQ_W  = 56;
   localparam int ACC_A = 40;
   localparam int ACC_B = 17;

   logic                 clk = 1'b0;
   logic                 rstN = 1'b0;
   logic                 start = 1'b0;
   logic [CNT_W-1:0]     num_samples = '0;
   logic                 valid_in = 1'b0;
   logic signed [DW-1:0] y_apx = '0;
   logic signed [DW-1:0] y_ref = '0;

   logic             a_busy, a_done, b_busy, b_done;
   logic [ACC_A-1:0] a_err_sum;
   logic [ACC_B-1:0] b_err_sum;
   logic [DW-1:0]    a_err_max, b_err_max;
   logic [CNT_W-1:0] a_err_cnt, b_err_cnt, a_sample_cnt, b_sample_cnt;
`ifdef ERR_SQ_EN
   logic [SQ_W-1:0]  a_err_sq_sum, b_err_sq_sum;
`endif

   fir_error_monitor #(.DW(DW), .CNT_W(CNT_W), .ACC_W(ACC_A), .SQ_W(SQ_W)) dut_a (
      .clk(clk), .rstN(rstN), .start(start), .num_samples(num_samples),
      .valid_in(valid_in), .y_apx(y_apx), .y_ref(y_ref),
      .busy(a_busy), .done(a_done), .err_sum(a_err_sum), .err_max(a_err_max),
      .err_cnt(a_err_cnt), .sample_cnt(a_sample_cnt)
`ifdef ERR_SQ_EN
      , .err_sq_sum(a_err_sq_sum)
`endif
   );

   fir_error_monitor #(.DW(DW), .CNT_W(CNT_W), .ACC_W(ACC_B), .SQ_W(SQ_W)) dut_b (
      .clk(clk), .rstN(rstN), .start(start), .num_samples(num_samples),
      .valid_in(valid_in), .y_apx(y_apx), .y_ref(y_ref),
      .busy(b_busy), .done(b_done), .err_sum(b_err_sum), .err_max(b_err_max),
      .err_cnt(b_err_cnt), .sample_cnt(b_sample_cnt)
`ifdef ERR_SQ_EN
      , .err_sq_sum(b_err_sq_sum)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      longint sum_a;
      longint sum_b;
      longint sq;
      int     mx;
      int     cnt;
      int     scnt;
      int     due;
   } exp_t;

   exp_t q[$];
   exp_t last;
   int   px[$];
   int   py[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic longint sat(input longint v, input int w);
      longint lim;
      lim = (longint'(1) <<< w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   // Scoreboard monitor: every done pulse must match the oldest outstanding window.
   always @(negedge clk) begin
      if (a_done === 1'b1 || b_done === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 64'(a_done), 64'(0));
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("done_cycle",   64'(cyc),          64'(e.due));
            chk("done_b",       64'(b_done),       64'(1));
            chk("busy_at_done", 64'(a_busy),       64'(0));
            chk("err_sum",      64'(a_err_sum),    64'(e.sum_a));
            chk("err_sum_sat",  64'(b_err_sum),    64'(e.sum_b));
            chk("err_max",      64'(a_err_max),    64'(e.mx));
            chk("err_cnt",      64'(a_err_cnt),    64'(e.cnt));
            chk("sample_cnt",   64'(a_sample_cnt), 64'(e.scnt));
            chk("sample_cnt_b", 64'(b_sample_cnt), 64'(e.scnt));
`ifdef ERR_SQ_EN
            chk("err_sq_sum",   64'(a_err_sq_sum), 64'(e.sq));
`endif
            last = e;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_data();
      y_apx = DW'($urandom);
      y_ref = DW'($urandom);
   endtask

   task automatic pick(input int mode, output int x, output int y);
      if (px.size() > 0) begin
         x = px.pop_front();
         y = py.pop_front();
      end else if (mode == 0) begin
         x = int'($urandom_range(0, 65535)) - 32768;
         y = int'($urandom_range(0, 65535)) - 32768;
      end else begin
         y = int'($urandom_range(0, 2000)) - 1000;
         x = y + int'($urandom_range(0, 4)) - 2;
      end
   endtask

   task automatic run_window(input int n, input int gap_pct, input bit extra, input int mode);
      exp_t   e;
      longint s = 0;
      longint sq = 0;
      int     mx = 0, cnt = 0, x, y, d, a, c0, t;
      step();
      start = 1'b1;
      num_samples = CNT_W'(n);
      valid_in = 1'b1;
      rnd_data();
      c0 = cyc;
      step();
      start = 1'b0;
      valid_in = 1'b0;
      e.due = 0;
      if (n == 0) begin
         e.due = c0 + 1;
      end else begin
         chk("busy_after_start", 64'(a_busy), 64'(1));
         for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
               valid_in = 1'b0;
               rnd_data();
               if (extra) begin
                  start = 1'b1;
                  num_samples = CNT_W'($urandom_range(1, 3));
               end
               step();
               start = 1'b0;
            end
            pick(mode, x, y);
            valid_in = 1'b1;
            y_apx = DW'(x);
            y_ref = DW'(y);
            if (extra) start = 1'($urandom_range(0, 1));
            d = x - y;
            a = (d < 0) ? -d : d;
            s += a;
            sq += longint'(d) * longint'(d);
            if (a > mx) mx = a;
            if (a != 0) cnt++;
            if (i == n - 1) e.due = cyc + 2;
            step();
            start = 1'b0;
            valid_in = 1'b0;
         end
      end
      e.sum_a = sat(s, ACC_A);
      e.sum_b = sat(s, ACC_B);
      e.sq    = sat(sq, SQ_W);
      e.mx    = mx;
      e.cnt   = cnt;
      e.scnt  = n;
      q.push_back(e);
      // Pairs presented after the window closes must not be counted.
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         rnd_data();
         step();
      end
      valid_in = 1'b0;
      t = 0;
      while (q.size() != 0 && t < 10) begin
         step();
         t++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", 64'(q.size()), 64'(0));
         q.delete();
      end
      step();
      step();
      chk("hold_err_sum",    64'(a_err_sum),    64'(e.sum_a));
      chk("hold_err_sum_b",  64'(b_err_sum),    64'(e.sum_b));
      chk("hold_err_max",    64'(a_err_max),    64'(e.mx));
      chk("hold_sample_cnt", 64'(a_sample_cnt), 64'(e.scnt));
      chk("hold_busy",       64'(a_busy),       64'(0));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"},   64'(a_busy),       64'(0));
      chk({tag, "_done"},   64'(a_done),       64'(0));
      chk({tag, "_sum"},    64'(a_err_sum),    64'(0));
      chk({tag, "_sum_b"},  64'(b_err_sum),    64'(0));
      chk({tag, "_max"},    64'(a_err_max),    64'(0));
      chk({tag, "_cnt"},    64'(a_err_cnt),    64'(0));
      chk({tag, "_scnt"},   64'(a_sample_cnt), 64'(0));
`ifdef ERR_SQ_EN
      chk({tag, "_sq"},     64'(a_err_sq_sum), 64'(0));
`endif
   endtask

   initial begin
      // Reset held with start asserted.
      rstN = 1'b0;
      start = 1'b1;
      num_samples = 16'd5;
      valid_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rnd_data();
         step();
         check_zero("reset");
      end
      rstN = 1'b1;
      start = 1'b0;
      valid_in = 1'b0;
      step();
      chk("idle_after_reset_busy", 64'(a_busy), 64'(0));
      step();
      chk("idle_after_reset_done", 64'(a_done), 64'(0));

      // Directed window.
      px = '{100, 105, -3, 0};
      py = '{100, 100,  2, 0};
      run_window(4, 0, 1'b0, 0);

      // Extreme pair.
      px = '{32767};
      py = '{-32768};
      run_window(1, 0, 1'b0, 0);

      // Saturation of the 17-bit accumulator.
      px = '{32767, 32767, 32767};
      py = '{-32768, -32768, -32768};
      run_window(3, 0, 1'b0, 0);

      // Empty window.
      run_window(0, 0, 1'b0, 0);

      // Randomized windows with gaps and stray start requests.
      for (int w = 0; w < 8; w++) begin
         run_window(int'($urandom_range(1, 20)), 30, 1'b1, w % 2);
      end

      // Reset in the middle of a window.
      step();
      start = 1'b1;
      num_samples = 16'd10;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         y_apx = 16'sd50;
         y_ref = 16'sd20;
         step();
      end
      rstN = 1'b0;
      valid_in = 1'b0;
      step();
      check_zero("midrst");
      rstN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1;
         rnd_data();
         step();
      end
      valid_in = 1'b0;
      repeat (4) step();
      check_zero("after_midrst");

      // Recovery window after the abort.
      run_window(int'($urandom_range(2, 12)), 20, 1'b0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fir_error_monitor.md
# fir_error_monitor

Error-measurement sink at the output end of the approximate FIR datapath. It reads each output sample of the approximate filter alongside the matching exact-arithmetic output, and accumulates error statistics over a software-sized window: sum of absolute error, maximum absolute error, and count of erroneous samples. It reports the results with a start/done handshake. It is used in simulation and on FPGA to characterise approximate adders inside the filter.

## Interface
- DW, 16, sample width of both filter outputs (signed)
- CNT_W, 16, width of the window length and sample counters
- ACC_W, 40, width of the absolute-error accumulator
- SQ_W, 56, width of the squared-error accumulator (used only with ERR_SQ_EN)
- clk  in  1  single clock, rising edge
- rstN  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- start  in  1  one-cycle request to open a measurement window; honoured only in IDLE
- num_samples  in  CNT_W  window length; latched when start is accepted
- valid_in  in  1  y_apx and y_ref hold a matched sample pair this cycle
- y_apx  in  DW  signed output of the approximate filter
- y_ref  in  DW  signed output of the exact filter, already latency-aligned by the caller
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse; results are final in this cycle
- err_sum  out  ACC_W  sum of |y_apx − y_ref|, saturating
- err_max  out  DW  maximum |y_apx − y_ref|, unsigned
- err_cnt  out  CNT_W  number of pairs with nonzero error
- sample_cnt  out  CNT_W  number of pairs accepted in the window
- err_sq_sum  out  SQ_W  sum of (y_apx − y_ref)², saturating (ERR_SQ_EN only)

## Operation
- FSM states:
  - IDLE: start=1 with num_samples≠0 → RUN; start=1 with num_samples=0 → DONE.
  - RUN: a pair is accepted when valid_in=1. Acceptance of pair number num_samples → DRAIN.
  - DRAIN: always → DONE next cycle.
  - DONE: done=1; always → IDLE next cycle.
- Accepting start:
  - Clears err_sum, err_max, err_cnt, sample_cnt and err_sq_sum.
  - Latches num_samples.
- start outside IDLE is ignored. valid_in outside RUN is ignored.
- Stage 1 (per accepted pair):
  - d = sign-extended y_apx − sign-extended y_ref, computed at DW+1 bits. No overflow is possible.
  - a = |d|, DW bits unsigned; the maximum value 2^DW−1 fits.
  - a, the flag (a≠0), and a stage valid bit are registered.
- Stage 2 (when the stage-1 valid bit is set):
  - err_sum += a; the result saturates at all-ones and stays there.
  - err_max = max(err_max, a).
  - err_cnt += (a≠0).
  - sample_cnt += 1.
- Results hold their values from DONE until the next accepted start.
- Reset returns the FSM to IDLE. All outputs read 0: busy=0, done=0, all statistics 0. Pipeline valid bits are cleared.
- rstN=0 in the middle of a window discards that window. No done pulse is produced.

## Timing
- start accepted in cycle 0 → busy=1 from cycle 1.
- The first pair can be accepted in cycle 1.
- Last pair accepted in cycle k:
  - stage 1 is valid in cycle k+1, which is DRAIN;
  - statistics are final and done=1 in cycle k+2, which is DONE;
  - busy=0 from cycle k+2.
- The earliest next start is accepted in cycle k+3 (IDLE).
- num_samples=0: start in cycle 0 → done=1 in cycle 1 with all statistics 0.
- Throughput: one pair per cycle. Gaps in valid_in are allowed and stall only the counting.

## Configuration
- ERR_SQ_EN defined:
  - stage 1 also registers d²; the product is 2·DW+2 bits and is reduced to unsigned 2·DW bits;
  - stage 2 accumulates d² into err_sq_sum, saturating at SQ_W all-ones;
  - err_sq_sum is cleared on start and on reset.
- ERR_SQ_EN undefined: the err_sq_sum port, the multiplier and the accumulator are absent. All other behaviour is identical.

## Structure
- Package fir_mon_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default width constants DW, CNT_W, ACC_W, SQ_W;
  - a saturating-add function shared by both accumulators.
- Sub-module fir_abs_diff is combinational. It maps y_apx, y_ref to d and a, and is instantiated once in stage 1.

## Test plan
- Reset: hold rstN=0 for 3 cycles with start=1 → busy=0, done=0, all outputs 0; the FSM stays in IDLE.
- Window of num_samples=4 with pairs (100,100), (105,100), (−3,2), (0,0) on consecutive cycles:
  - done comes 2 cycles after the 4th pair;
  - err_sum=10, err_max=5, err_cnt=2, sample_cnt=4.
- Extreme values: pair (32767, −32768) with num_samples=1 → err_max=65535, err_sum=65535, err_cnt=1.
- Saturation: ACC_W=17, three pairs of (32767, −32768) → err_sum=131071, held at saturation.
- num_samples=0 and start pulse → done in the next cycle, all statistics 0.
- start during RUN, valid_in gaps, and rstN mid-window:
  - the extra start is ignored;
  - the counts are unaffected by the gaps;
  - rstN=0 in the middle of a window returns the block to IDLE with zeros and no done pulse.
